gray_step_counter: RTL and testbench

Prescaled up/down Gray-code counter that drives the seven-segment decoder stage. Count state is held in Gray code, so only one bit toggles per step. A registered binary view of the same value feeds the decoder's 4-bit input directly. Steps are paced by an internal prescaler, so a fast board clock produces a human-readable display rate.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_prescaler.sv | 41 ++++
 rtl/gray_step_counter.sv | 91 +++++++++
 tb/tb_gray_step_counter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray/binary conversion helpers for the step counter
//
// Purpose: width-generic Gray<->binary conversion and display constants.
// Contents:
//   DISP_W   - width of the seven-segment decoder input nibble
//   MAX_W    - widest counter the helpers support; callers zero-extend to it
//   bin2gray - binary to Gray
//   gray2bin - Gray to binary (prefix-XOR from the MSB down)
package gray_pkg;

  localparam int DISP_W = 4;
  localparam int MAX_W  = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bv);
    return bv ^ (bv >> 1);
  endfunction

  // Zero-extended upper Gray bits decode to zero, so a narrow counter
  // converts correctly through the full-width helper.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gv);
    logic [MAX_W-1:0] bv;
    bv[MAX_W-1] = gv[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      bv[i] = bv[i+1] ^ gv[i];
    end
    return bv;
  endfunction

endpackage

// File: rtl/gray_prescaler.sv
// rtl/gray_prescaler.sv - enable-gated prescaler producing one step per PRESCALE cycles
//
// Purpose: counts enabled cycles and flags the cycle on which a count step is due.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   en   in  count enable; pcnt holds while low
//   clr  in  restart the interval (driven by load); suppresses step
//   step out combinational: en & ~clr & (pcnt == PRESCALE-1)
module gray_prescaler #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  // With PRESCALE = 1, LAST is 0 so pcnt never leaves 0 and every enabled
  // non-clear cycle steps.
  assign step = en & ~clr & (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == LAST) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/gray_step_counter.sv
// rtl/gray_step_counter.sv - prescaled up/down Gray-code counter feeding the display decoder
//
// Purpose: holds the count in Gray code and steps it once per PRESCALE enabled
// cycles; a registered binary view drives the seven-segment decoder.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (overrides load and en)
//   en       in  count enable; prescaler and count hold while low
//   up_dn    in  1 = count up, 0 = count down (sampled on the step cycle)
//   load     in  synchronous load strobe, priority over step and en
//   load_val in  binary value to load
//   gray_out out registered Gray count
//   bin_out  out registered binary equivalent of gray_out
//   tick     out one-cycle pulse when a stepped value first appears
//   wrap     out one-cycle pulse with tick when the step crosses max<->0
module gray_step_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tick,
  output logic             wrap
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] b_cur;
  logic [WIDTH-1:0] b_step;
  logic [WIDTH-1:0] b_nxt;
  logic             step;
  logic             tick_nxt;
  logic             wrap_nxt;

  gray_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .step(step)
  );

  assign b_cur  = WIDTH'(gray2bin(MAX_W'(g)));
  assign b_step = up_dn ? (b_cur + WIDTH'(1)) : (b_cur - WIDTH'(1));

  always_comb begin
    g_nxt    = g;
    b_nxt    = b_cur;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (load) begin
      g_nxt = WIDTH'(bin2gray(MAX_W'(load_val)));
      b_nxt = load_val;
    end else if (step) begin
      g_nxt    = WIDTH'(bin2gray(MAX_W'(b_step)));
      b_nxt    = b_step;
      tick_nxt = 1'b1;
      // Boundary test uses the pre-step value in the stepping direction.
      wrap_nxt = up_dn ? (b_cur == {WIDTH{1'b1}}) : (b_cur == '0);
    end
  end

  // bin_out comes from the same next-state value as g, so the two views
  // can never disagree on any cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      g       <= '0;
      bin_out <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      g       <= g_nxt;
      bin_out <= b_nxt;
      tick    <= tick_nxt;
      wrap    <= wrap_nxt;
    end
  end

  assign gray_out = g;

endmodule

// File: tb/tb_gray_step_counter.sv
// tb/tb_gray_step_counter.sv - scoreboard bench for gray_step_counter (WIDTH=4, PRESCALE=4)
module tb_gray_step_counter;

  localparam int W  = 4;
  localparam int PS = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         tick;
  logic         wrap;

  gray_step_counter #(
    .WIDTH(W),
    .PRESCALE(PS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_dn   (up_dn),
    .load    (load),
    .load_val(load_val),
    .gray_out(gray_out),
    .bin_out (bin_out),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain binary count plus prescaler position.
  int m_b = 0;
  int m_p = 0;
  int m_tick = 0;
  int m_wrap = 0;

  logic [2*W+1:0] sb[$];
  logic [2*W+1:0] exp_v;

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] bb;
    bb = W'(b);
    return bb ^ (bb >> 1);
  endfunction

  // Advance the model on the current inputs, queue the expectation, and
  // clock the DUT; outputs are then sampled 1ns after the edge.
  task automatic run_cycle();
    m_tick = 0;
    m_wrap = 0;
    if (rst) begin
      m_b = 0;
      m_p = 0;
    end else if (load) begin
      m_b = int'(load_val);
      m_p = 0;
    end else if (en) begin
      if (m_p == PS - 1) begin
        m_p = 0;
        m_tick = 1;
        if (up_dn) begin
          m_wrap = (m_b == 15) ? 1 : 0;
          m_b = (m_b + 1) % 16;
        end else begin
          m_wrap = (m_b == 0) ? 1 : 0;
          m_b = (m_b + 15) % 16;
        end
      end else begin
        m_p = m_p + 1;
      end
    end
    sb.push_back({to_gray(m_b), W'(m_b), m_tick[0], m_wrap[0]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    up_dn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL reset_cycle got=%b exp=%b", {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({gray_out, bin_out, tick, wrap} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_state got=%b exp=%b", {gray_out, bin_out, tick, wrap}, 10'b0);
    end
  endtask

  task automatic test_first_step();
    do_reset();
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL first_step edge=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
    vectors++;
    if ({gray_out, bin_out, tick, wrap} !== {4'b0001, 4'd1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL first_step_value got=%b exp=%b", {gray_out, bin_out, tick, wrap},
               {4'b0001, 4'd1, 1'b1, 1'b0});
    end
    run_cycle();
    exp_v = sb.pop_front();
    vectors++;
    if (tick !== 1'b0 || {gray_out, bin_out, tick, wrap} !== exp_v) begin
      miscompares++;
      $display("FAIL tick_width got=%b exp=%b", {gray_out, bin_out, tick, wrap}, exp_v);
    end
  endtask

  task automatic test_up_sweep();
    logic [W-1:0] prev_g;
    int steps = 0;
    int wraps = 0;
    do_reset();
    en = 1'b1;
    up_dn = 1'b1;
    prev_g = 4'b0000;
    for (int i = 0; i < 16 * PS; i++) begin
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL up_sweep cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
      if (tick === 1'b1) begin
        steps++;
        vectors++;
        if ($countones(prev_g ^ gray_out) != 1) begin
          miscompares++;
          $display("FAIL up_hamming step=%0d got=%b->%b exp=distance 1", steps, prev_g, gray_out);
        end
        if (wrap === 1'b1) begin
          wraps++;
          vectors++;
          if (bin_out !== 4'd0 || gray_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL up_wrap_value got=%0d/%b exp=0/0000", bin_out, gray_out);
          end
        end
        prev_g = gray_out;
      end
    end
    vectors++;
    if (steps != 16 || wraps != 1) begin
      miscompares++;
      $display("FAIL up_sweep_counts got steps=%0d wraps=%0d exp steps=16 wraps=1", steps, wraps);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1'b1;
    up_dn = 1'b0;
    for (int i = 0; i < PS; i++) begin
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL down_wrap cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
    vectors++;
    if ({gray_out, bin_out, tick, wrap} !== {4'b1000, 4'd15, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL down_wrap_value got=%b exp=%b", {gray_out, bin_out, tick, wrap},
               {4'b1000, 4'd15, 1'b1, 1'b1});
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    en = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < PS; i++) begin
      if (i == PS - 1) begin
        load = 1'b1;
        load_val = 4'd9;
      end
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL load_priority cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
    load = 1'b0;
    vectors++;
    if ({gray_out, bin_out, tick, wrap} !== {4'b1101, 4'd9, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL load_value got=%b exp=%b", {gray_out, bin_out, tick, wrap},
               {4'b1101, 4'd9, 1'b0, 1'b0});
    end
    for (int i = 1; i <= PS; i++) begin
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL after_load cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
    vectors++;
    if (bin_out !== 4'd10 || tick !== 1'b1) begin
      miscompares++;
      $display("FAIL after_load_step got bin=%0d tick=%b exp bin=10 tick=1", bin_out, tick);
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    up_dn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      en = (i < 2 || i >= 12) ? 1'b1 : 1'b0;
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL enable_gap cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
      if (i < 13 && (gray_out !== 4'b0000 || tick !== 1'b0)) begin
        miscompares++;
        $display("FAIL gap_stable cyc=%0d got gray=%b tick=%b exp gray=0000 tick=0", i, gray_out, tick);
      end
    end
    vectors++;
    if (gray_out !== 4'b0001 || tick !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_resume got gray=%b tick=%b exp gray=0001 tick=1", gray_out, tick);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load = 1'b1;
    load_val = 4'd6;
    en = 1'b1;
    run_cycle();
    void'(sb.pop_front());
    load = 1'b0;
    for (int i = 0; i < PS - 1; i++) begin
      run_cycle();
      void'(sb.pop_front());
    end
    vectors++;
    if (bin_out !== 4'd6) begin
      miscompares++;
      $display("FAIL mid_setup got bin=%0d exp bin=6", bin_out);
    end
    rst = 1'b1;
    run_cycle();
    exp_v = sb.pop_front();
    vectors++;
    if ({gray_out, bin_out, tick, wrap} !== 10'b0 || exp_v !== 10'b0) begin
      miscompares++;
      $display("FAIL mid_reset got=%b exp=%b", {gray_out, bin_out, tick, wrap}, 10'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= PS; i++) begin
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v || tick !== ((i == PS) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL mid_restart cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
      up_dn = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      load = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      load_val = W'($urandom_range(0, 15));
      rst = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
      run_cycle();
      exp_v = sb.pop_front();
      vectors++;
      if ({gray_out, bin_out, tick, wrap} !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, {gray_out, bin_out, tick, wrap}, exp_v);
      end
    end
    rst = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_up_sweep();
    test_down_wrap();
    test_load_priority();
    test_enable_gap();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
